// File: rtl/aes_128_inv_control_4clk_if.sv
// Control/status bundle between the AES-128 inverse-cipher sequencer and its
// requester/datapath. The master drives requests; the slave (sequencer) drives strobes.
interface aes_128_inv_control_4clk_if;
  logic       in_en;
  logic       key_new;
  logic       busy;
  logic       key_exp_step;
  logic       load_state;
  logic       key_inv_step;
  logic       round_end;
  logic       inv_mixcol_bypass;
  logic [3:0] round_idx;
  logic       out_en;
  logic       in_en_collision_irq_pulse;

  modport master (
    output in_en, key_new,
    input  busy, key_exp_step, load_state, key_inv_step, round_end,
           inv_mixcol_bypass, round_idx, out_en, in_en_collision_irq_pulse
  );

  modport slave (
    input  in_en, key_new,
    output busy, key_exp_step, load_state, key_inv_step, round_end,
           inv_mixcol_bypass, round_idx, out_en, in_en_collision_irq_pulse
  );
endinterface

// File: rtl/aes_128_inv_control_4clk.sv
// AES-128 decryption sequencer, 4 clocks per round. Caches round key 10 across
// blocks; a key change forces a forward expansion before the next block.
module aes_128_inv_control_4clk (
  input  logic                         clk,
  input  logic                         kill,
  aes_128_inv_control_4clk_if.slave    bus
);

  typedef enum logic [2:0] {S_IDLE, S_KEY_EXP, S_LOAD, S_ROUND, S_DONE} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_phase, w_phase_nxt;
  logic [3:0] r_round, w_round_nxt;
  logic       r_key_valid, w_key_valid_nxt;
  logic       r_key_stale, w_key_stale_nxt;
  logic       r_irq;
  logic       w_phase_last;
  logic       w_busy;

  assign w_phase_last = (r_phase == 2'd3);
  assign w_busy       = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_round_nxt     = r_round;
    w_key_valid_nxt = r_key_valid;
    w_key_stale_nxt = r_key_stale;

    // A key change mid-block lets the block finish on the old key, then drops the cache.
    if (w_busy && bus.key_new)
      w_key_stale_nxt = 1'b1;

    case (r_state)
      S_IDLE: begin
        w_phase_nxt = 2'd0;
        w_round_nxt = 4'd0;
        if (bus.in_en) begin
          if (r_key_valid && !bus.key_new) begin
            w_state_nxt = S_LOAD;
            w_round_nxt = 4'd10;
          end else begin
            w_state_nxt     = S_KEY_EXP;
            w_round_nxt     = 4'd1;
            w_key_valid_nxt = 1'b0;
          end
        end else if (bus.key_new) begin
          w_key_valid_nxt = 1'b0;
        end
      end
      S_KEY_EXP: begin
        if (w_phase_last) begin
          w_phase_nxt = 2'd0;
          if (r_round == 4'd10) begin
            w_state_nxt     = S_LOAD;
            w_key_valid_nxt = 1'b1;
          end else begin
            w_round_nxt = r_round + 4'd1;
          end
        end else begin
          w_phase_nxt = r_phase + 2'd1;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_ROUND;
        w_phase_nxt = 2'd0;
        w_round_nxt = 4'd9;
      end
      S_ROUND: begin
        if (w_phase_last) begin
          w_phase_nxt = 2'd0;
          if (r_round == 4'd0)
            w_state_nxt = S_DONE;
          else
            w_round_nxt = r_round - 4'd1;
        end else begin
          w_phase_nxt = r_phase + 2'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = 2'd0;
        w_round_nxt = 4'd0;
        // A key_new landing on DONE itself is treated as stale too, so it is never lost.
        if (r_key_stale || bus.key_new) begin
          w_key_valid_nxt = 1'b0;
          w_key_stale_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = 2'd0;
        w_round_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      r_state     <= S_IDLE;
      r_phase     <= 2'd0;
      r_round     <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_stale <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_round     <= w_round_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_stale <= w_key_stale_nxt;
      r_irq       <= bus.in_en & w_busy;
    end
  end

  assign bus.busy                      = w_busy;
  assign bus.key_exp_step              = (r_state == S_KEY_EXP) && w_phase_last;
  assign bus.load_state                = (r_state == S_LOAD);
  assign bus.key_inv_step              = (r_state == S_ROUND) && (r_phase == 2'd0);
  assign bus.round_end                 = (r_state == S_ROUND) && w_phase_last;
  assign bus.inv_mixcol_bypass         = (r_state == S_ROUND) && (r_round == 4'd0);
  assign bus.round_idx                 = r_round;
  assign bus.out_en                    = (r_state == S_DONE);
  assign bus.in_en_collision_irq_pulse = r_irq;

endmodule

// File: tb/tb_aes_128_inv_control_4clk.sv
// Directed bench for the AES-128 inverse-cipher sequencer: cached/uncached blocks,
// collisions, key changes, kill. Expected traces are built from the cycle timing.
module tb_aes_128_inv_control_4clk;
  logic clk = 1'b0;
  logic kill;
  always #5 clk = ~clk;

  aes_128_inv_control_4clk_if bus ();

  aes_128_inv_control_4clk dut (
    .clk  (clk),
    .kill (kill),
    .bus  (bus)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [11:0] trace [0:127];

  // {busy, key_exp_step, load_state, key_inv_step, round_end, bypass, round_idx[3:0], out_en, irq}
  function logic [11:0] sample();
    return {bus.busy, bus.key_exp_step, bus.load_state, bus.key_inv_step, bus.round_end,
            bus.inv_mixcol_bypass, bus.round_idx, bus.out_en, bus.in_en_collision_irq_pulse};
  endfunction

  // Expected outputs c cycles after in_en; exp_len is 40 for an uncached key, 0 for cached.
  function automatic logic [11:0] expv(int c, int exp_len);
    logic busy, kx, ld, ki, re, by, oe;
    logic [3:0] idx;
    int r;
    {busy, kx, ld, ki, re, by, oe} = '0;
    idx = 4'd0;
    if (c >= 1 && c <= exp_len) begin
      busy = 1'b1; kx = (c % 4 == 0); idx = 4'((c - 1) / 4 + 1);
    end else if (c == exp_len + 1) begin
      busy = 1'b1; ld = 1'b1; idx = 4'd10;
    end else if (c >= exp_len + 2 && c <= exp_len + 41) begin
      r = c - exp_len - 2;
      busy = 1'b1; idx = 4'(9 - r / 4);
      ki = (r % 4 == 0); re = (r % 4 == 3); by = (idx == 4'd0);
    end else if (c == exp_len + 42) begin
      busy = 1'b1; oe = 1'b1;
    end
    return {busy, kx, ld, ki, re, by, idx, oe, 1'b0};
  endfunction

  task automatic start_block(input bit with_key_new);
    bus.in_en   = 1'b1;
    bus.key_new = with_key_new;
    @(posedge clk); #1;
    bus.in_en   = 1'b0;
    bus.key_new = 1'b0;
  endtask

  // inj_kind: 0 none, 1 in_en, 2 key_new, 3 kill -- asserted during cycle inj_cyc.
  task automatic capture(input int n, input int inj_cyc, input int inj_kind);
    for (int c = 1; c <= n; c++) begin
      trace[c] = sample();
      if (c == inj_cyc) begin
        case (inj_kind)
          1: bus.in_en   = 1'b1;
          2: bus.key_new = 1'b1;
          3: kill        = 1'b1;
          default: ;
        endcase
      end
      @(posedge clk); #1;
      bus.in_en   = 1'b0;
      bus.key_new = 1'b0;
      kill        = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [11:0] got;
    kill = 1'b1; bus.in_en = 1'b0; bus.key_new = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = sample();
    tot_cnt++;
    if (got !== 12'h000) $display("FAIL reset_outputs got %h want 000", got);
    else pass_cnt++;
    kill = 1'b0;
    @(posedge clk); #1;
    got = sample();
    tot_cnt++;
    if (got !== 12'h000) $display("FAIL idle_after_reset got %h want 000", got);
    else pass_cnt++;
  endtask

  task automatic test_uncached();
    int nkx, nki;
    logic [11:0] e;
    start_block(1'b0);
    capture(86, 0, 0);
    nkx = 0; nki = 0;
    for (int c = 1; c <= 86; c++) begin
      nkx += int'(trace[c][10]);
      nki += int'(trace[c][8]);
      e = expv(c, 40);
      tot_cnt++;
      if (trace[c] !== e) $display("FAIL uncached c=%0d got %h want %h", c, trace[c], e);
      else pass_cnt++;
    end
    tot_cnt++;
    if (nkx !== 10) $display("FAIL uncached_kexp_count got %0d want 10", nkx);
    else pass_cnt++;
    tot_cnt++;
    if (nki !== 10) $display("FAIL uncached_kinv_count got %0d want 10", nki);
    else pass_cnt++;
  endtask

  task automatic test_cached();
    logic [11:0] e;
    start_block(1'b0);
    capture(46, 0, 0);
    for (int c = 1; c <= 46; c++) begin
      e = expv(c, 0);
      tot_cnt++;
      if (trace[c] !== e) $display("FAIL cached c=%0d got %h want %h", c, trace[c], e);
      else pass_cnt++;
    end
  endtask

  task automatic test_collision();
    logic [11:0] e;
    // Mid-round collision, then a collision on the DONE cycle.
    for (int run = 0; run < 2; run++) begin
      int at;
      at = (run == 0) ? 20 : 42;
      start_block(1'b0);
      capture(46, at, 1);
      for (int c = 1; c <= 46; c++) begin
        e = expv(c, 0);
        if (c == at + 1) e[0] = 1'b1;
        tot_cnt++;
        if (trace[c] !== e) $display("FAIL collision_at%0d c=%0d got %h want %h", at, c, trace[c], e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_key_change_busy();
    logic [11:0] e;
    start_block(1'b0);
    capture(46, 10, 2);
    for (int c = 1; c <= 46; c++) begin
      e = expv(c, 0);
      tot_cnt++;
      if (trace[c] !== e) $display("FAIL keychg_old_block c=%0d got %h want %h", c, trace[c], e);
      else pass_cnt++;
    end
    start_block(1'b0);
    capture(86, 0, 0);
    for (int c = 1; c <= 86; c++) begin
      e = expv(c, 40);
      tot_cnt++;
      if (trace[c] !== e) $display("FAIL keychg_next_block c=%0d got %h want %h", c, trace[c], e);
      else pass_cnt++;
    end
  endtask

  task automatic test_simultaneous();
    logic [11:0] e;
    // key_new with in_en while cached; another key_new on the last expansion cycle.
    start_block(1'b1);
    capture(86, 40, 2);
    for (int c = 1; c <= 86; c++) begin
      e = expv(c, 40);
      tot_cnt++;
      if (trace[c] !== e) $display("FAIL simul_block c=%0d got %h want %h", c, trace[c], e);
      else pass_cnt++;
    end
    start_block(1'b0);
    capture(86, 0, 0);
    for (int c = 1; c <= 86; c++) begin
      e = expv(c, 40);
      tot_cnt++;
      if (trace[c] !== e) $display("FAIL expand_end_stale c=%0d got %h want %h", c, trace[c], e);
      else pass_cnt++;
    end
  endtask

  task automatic test_kill();
    logic [11:0] e;
    // Key is cached here: kill mid-round, then kill mid-expansion, then a full uncached block.
    for (int run = 0; run < 3; run++) begin
      int at, len;
      at  = (run == 0) ? 30 : (run == 1) ? 15 : 0;
      len = (run == 0) ? 0 : 40;
      start_block(1'b0);
      capture(86, at, (run == 2) ? 0 : 3);
      for (int c = 1; c <= 86; c++) begin
        e = (at != 0 && c > at) ? 12'h000 : expv(c, len);
        tot_cnt++;
        if (trace[c] !== e) $display("FAIL kill_run%0d c=%0d got %h want %h", run, c, trace[c], e);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    kill = 1'b1;
    bus.in_en = 1'b0;
    bus.key_new = 1'b0;
    test_reset();
    test_uncached();
    test_cached();
    test_collision();
    test_key_change_busy();
    test_simultaneous();
    test_cached();
    test_kill();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
